// File: rtl/lifo_arb_pkg.sv
// Shared types and constants for the LIFO arbiter slice.
package lifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } state_e;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/lifo_arbiter_if.sv
// Requester-side bus of the LIFO arbiter: per-requester request/op/data in,
// per-requester grant/error/read-valid out, shared read data bus.
interface lifo_arbiter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       op;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       err;
   logic [NREQ-1:0]       rvalid;
   logic [WIDTH-1:0]      rdata;

   // Client side
   modport master (
      output req, op, wdata,
      input  gnt, err, rvalid, rdata
   );

   // Arbiter side
   modport slave (
      input  req, op, wdata,
      output gnt, err, rvalid, rdata
   );
endinterface

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx
);
   localparam int unsigned IDX_W = $clog2(NREQ);

   logic             found;
   logic [IDX_W-1:0] k;

   // Scan from ptr upwards, wrapping, and take the first requester found
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = IDX_W'((32'(ptr) + i) % NREQ);
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end
endmodule

// File: rtl/lifo_arbiter.sv
// Arbitrates NREQ requesters onto one LIFO, round-robin, one op at a time.
// Illegal ops (push on full, pop on empty) are granted with an err pulse.
// Optional statistics (err_count, level) enabled by defining LIFO_ARB_STATS_EN.
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned NREQ  = 4
) (
   input  logic             clk,
   input  logic             rst,
   lifo_arbiter_if.slave    bus,
   output logic             lifo_push,
   output logic             lifo_pop,
   output logic [WIDTH-1:0] lifo_data_in,
   input  logic [WIDTH-1:0] lifo_data_out,
   input  logic             lifo_empty,
   input  logic             lifo_full
`ifdef LIFO_ARB_STATS_EN
   ,
   output logic [ERR_CNT_W-1:0]       err_count,
   output logic [$clog2(DEPTH+1)-1:0] level
`endif
);
   localparam int unsigned IDX_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || DEPTH < 1) begin : g_bad_cfg
      $error("lifo_arbiter: NREQ must be 2..8 and DEPTH at least 1");
   end

   state_e           state_q;
   logic [IDX_W-1:0] ptr_q, owner_q, win_idx, ptr_next;
   logic [NREQ-1:0]  win_gnt, owner_oh;
   logic [NREQ-1:0]  gnt_q, err_q, rvalid_q;
   logic [WIDTH-1:0] rdata_q, data_in_q, win_wdata;
   logic             win_op, push_q, pop_q;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (win_gnt),
      .idx (win_idx)
   );

   // Winner's op/data, next pointer and one-hot owner decode
   always_comb begin
      win_op    = bus.op[win_idx];
      win_wdata = bus.wdata[win_idx*WIDTH +: WIDTH];
      ptr_next  = win_idx + 1'b1;
      if (win_idx == IDX_W'(NREQ - 1)) ptr_next = '0;
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
   end

   // FSM. The legality check is made as the winner is latched so that gnt/err and the
   // LIFO strobe are registered into the ISSUE cycle; full/empty cannot move in between
   // because this block is the LIFO's only driver.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         err_q     <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
         data_in_q <= '0;
         push_q    <= 1'b0;
         pop_q     <= 1'b0;
      end else begin
         gnt_q    <= '0;
         err_q    <= '0;
         rvalid_q <= '0;
         push_q   <= 1'b0;
         pop_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  state_q <= ISSUE;
                  owner_q <= win_idx;
                  ptr_q   <= ptr_next;
                  gnt_q   <= win_gnt;
                  if (win_op == OP_PUSH) begin
                     if (!lifo_full) begin
                        push_q    <= 1'b1;
                        data_in_q <= win_wdata;
                     end else begin
                        err_q <= win_gnt;
                     end
                  end else if (!lifo_empty) begin
                     pop_q <= 1'b1;
                  end else begin
                     err_q <= win_gnt;
                  end
               end
            end
            ISSUE:   state_q <= pop_q ? WAIT_RD : IDLE;
            WAIT_RD: begin
               rdata_q  <= lifo_data_out;
               rvalid_q <= owner_oh;
               state_q  <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.err      = err_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.rdata    = rdata_q;
   assign lifo_push    = push_q;
   assign lifo_pop     = pop_q;
   assign lifo_data_in = data_in_q;

`ifdef LIFO_ARB_STATS_EN
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [LVL_W-1:0]     level_q;

   // Saturating reject counter and occupancy from the strobes actually issued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
         level_q   <= '0;
      end else begin
         if (|err_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
         if (push_q) level_q <= level_q + 1'b1;
         else if (pop_q) level_q <= level_q - 1'b1;
      end
   end

   assign err_count = err_cnt_q;
   assign level     = level_q;
`endif
endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a behavioural 4-deep LIFO sharing rst.
module tb_lifo_arbiter;
   import lifo_arb_pkg::*;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NREQ  = 4;

   logic clk = 1'b0;
   logic rst;
   logic lifo_push, lifo_pop, lifo_empty, lifo_full;
   logic [WIDTH-1:0] lifo_data_in, lifo_data_out;
`ifdef LIFO_ARB_STATS_EN
   logic [15:0] err_count;
   logic [2:0]  level;
`endif

   lifo_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   lifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .lifo_push     (lifo_push),
      .lifo_pop      (lifo_pop),
      .lifo_data_in  (lifo_data_in),
      .lifo_data_out (lifo_data_out),
      .lifo_empty    (lifo_empty),
      .lifo_full     (lifo_full)
`ifdef LIFO_ARB_STATS_EN
      ,
      .err_count     (err_count),
      .level         (level)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural LIFO: registered data_out, valid the cycle after pop
   logic [WIDTH-1:0] stk [DEPTH];
   logic [2:0]       cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         lifo_data_out <= '0;
      end else if (lifo_push && cnt < 3'd4) begin
         stk[cnt[1:0]] <= lifo_data_in;
         cnt           <= cnt + 3'd1;
      end else if (lifo_pop && cnt != 3'd0) begin
         lifo_data_out <= stk[cnt[1:0] - 2'd1];
         cnt           <= cnt - 3'd1;
      end
   end
   assign lifo_empty = (cnt == 3'd0);
   assign lifo_full  = (cnt == 3'd4);

   typedef struct {
      logic [1:0]  who;
      logic        op;
      logic [15:0] wdata;
      logic        rej;
      logic [15:0] rdata;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bus.req   = '0;
      bus.op    = '0;
      bus.wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Called #1 after a posedge with the DUT idle; returns #1 after a posedge, idle again
   task automatic run_txn(input vec_t v, input string tag);
      logic [3:0] oh;
      oh = 4'(1 << v.who);
      bus.req[v.who]                = 1'b1;
      bus.op[v.who]                 = v.op;
      bus.wdata[v.who*16 +: 16]     = v.wdata;
      @(negedge clk);
      check({tag, " gnt early"}, 32'(bus.gnt), 32'h0);
      @(negedge clk);
      check({tag, " gnt"}, 32'(bus.gnt), 32'(oh));
      check({tag, " err"}, 32'(bus.err), v.rej ? 32'(oh) : 32'h0);
      check({tag, " push"}, 32'(lifo_push), 32'(v.op == OP_PUSH && !v.rej));
      check({tag, " pop"}, 32'(lifo_pop), 32'(v.op == OP_POP && !v.rej));
      if (v.op == OP_PUSH && !v.rej) check({tag, " data_in"}, 32'(lifo_data_in), 32'(v.wdata));
      bus.req[v.who] = 1'b0;
      if (v.op == OP_POP && !v.rej) begin
         @(negedge clk);
         check({tag, " rvalid early"}, 32'(bus.rvalid), 32'h0);
         @(negedge clk);
         check({tag, " rvalid"}, 32'(bus.rvalid), 32'(oh));
         check({tag, " rdata"}, 32'(bus.rdata), 32'(v.rdata));
      end else begin
         @(negedge clk);
         check({tag, " no rvalid"}, 32'(bus.rvalid), 32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   // Sample negedges until some gnt appears; expiry is a failure
   task automatic wait_gnt(input string tag, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.gnt != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s: got no gnt expected gnt within 12 cycles", tag);
      end
   endtask

   vec_t vecs [13];
   vec_t pops [4];

   initial begin
      logic       ok;
      logic [3:0] seen;

      vecs[0]  = '{2'd3, OP_POP,  16'h0000, 1'b1, 16'h0000};
      vecs[1]  = '{2'd0, OP_PUSH, 16'hA5A5, 1'b0, 16'h0000};
      vecs[2]  = '{2'd0, OP_POP,  16'h0000, 1'b0, 16'hA5A5};
      vecs[3]  = '{2'd0, OP_PUSH, 16'h0001, 1'b0, 16'h0000};
      vecs[4]  = '{2'd1, OP_PUSH, 16'h0002, 1'b0, 16'h0000};
      vecs[5]  = '{2'd2, OP_PUSH, 16'h0003, 1'b0, 16'h0000};
      vecs[6]  = '{2'd3, OP_PUSH, 16'h0004, 1'b0, 16'h0000};
      vecs[7]  = '{2'd1, OP_PUSH, 16'hDEAD, 1'b1, 16'h0000};
      vecs[8]  = '{2'd2, OP_POP,  16'h0000, 1'b0, 16'h0004};
      vecs[9]  = '{2'd2, OP_POP,  16'h0000, 1'b0, 16'h0003};
      vecs[10] = '{2'd2, OP_POP,  16'h0000, 1'b0, 16'h0002};
      vecs[11] = '{2'd2, OP_POP,  16'h0000, 1'b0, 16'h0001};
      vecs[12] = '{2'd0, OP_POP,  16'h0000, 1'b1, 16'h0000};

      pops[0] = '{2'd2, OP_POP, 16'h0000, 1'b0, 16'h4444};
      pops[1] = '{2'd2, OP_POP, 16'h0000, 1'b0, 16'h3333};
      pops[2] = '{2'd2, OP_POP, 16'h0000, 1'b0, 16'h2222};
      pops[3] = '{2'd2, OP_POP, 16'h0000, 1'b0, 16'h1111};

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst gnt", 32'(bus.gnt), 32'h0);
      check("rst err", 32'(bus.err), 32'h0);
      check("rst rvalid", 32'(bus.rvalid), 32'h0);
      check("rst rdata", 32'(bus.rdata), 32'h0);
      check("rst push", 32'(lifo_push), 32'h0);
      check("rst pop", 32'(lifo_pop), 32'h0);
`ifdef LIFO_ARB_STATS_EN
      check("rst err_count", 32'(err_count), 32'h0);
      check("rst level", 32'(level), 32'h0);
`endif
      @(posedge clk);
      #1;

      // Single-requester table: empty reject, push/pop, fill, full reject, drain
      for (int i = 0; i < 13; i++) run_txn(vecs[i], $sformatf("v%0d", i));

      // All four push together from reset: grants in order 0..3
      do_reset();
      bus.req   = 4'hF;
      bus.op    = 4'h0;
      bus.wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      for (int k = 0; k < 4; k++) begin
         wait_gnt($sformatf("multi%0d", k), ok);
         if (ok) begin
            check($sformatf("multi%0d gnt", k), 32'(bus.gnt), 32'(1 << k));
            check($sformatf("multi%0d push", k), 32'(lifo_push), 32'h1);
            check($sformatf("multi%0d data_in", k), 32'(lifo_data_in),
                  32'h1111 * 32'(k + 1));
         end
         bus.req = bus.req & ~4'(1 << k);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) run_txn(pops[i], $sformatf("lifo_pop%0d", i));

      // Fairness: req0/req1 held for 8 grants; the last four pushes hit full
      do_reset();
      bus.op    = 4'h0;
      bus.wdata = {16'h0, 16'h0, 16'h0B0B, 16'h0A0A};
      bus.req   = 4'b0011;
      for (int g = 0; g < 8; g++) begin
         wait_gnt($sformatf("fair%0d", g), ok);
         if (ok) begin
            check($sformatf("fair%0d gnt", g), 32'(bus.gnt), 32'(1 << (g % 2)));
            check($sformatf("fair%0d err", g), 32'(bus.err), (g >= 4) ? 32'(1 << (g % 2)) : 32'h0);
            check($sformatf("fair%0d push", g), 32'(lifo_push), 32'(g < 4));
         end
      end
      bus.req = '0;
      repeat (2) @(posedge clk);
`ifdef LIFO_ARB_STATS_EN
      #1;
      check("fair err_count", 32'(err_count), 32'd4);
      check("fair level", 32'(level), 32'd4);
`endif
      @(posedge clk);
      #1;

      // Reset during WAIT_RD of a pop
      do_reset();
      run_txn('{2'd0, OP_PUSH, 16'h7777, 1'b0, 16'h0000}, "pre");
      bus.req[1] = 1'b1;
      bus.op[1]  = OP_POP;
      @(negedge clk);
      @(negedge clk);
      check("midrst pop strobe", 32'(lifo_pop), 32'h1);
      bus.req[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst gnt", 32'(bus.gnt), 32'h0);
      check("midrst err", 32'(bus.err), 32'h0);
      check("midrst rvalid", 32'(bus.rvalid), 32'h0);
      check("midrst rdata", 32'(bus.rdata), 32'h0);
      check("midrst push", 32'(lifo_push), 32'h0);
      check("midrst pop", 32'(lifo_pop), 32'h0);
      check("midrst data_in", 32'(lifo_data_in), 32'h0);
`ifdef LIFO_ARB_STATS_EN
      check("midrst err_count", 32'(err_count), 32'h0);
      check("midrst level", 32'(level), 32'h0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      seen = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | bus.rvalid | bus.gnt | bus.err;
      end
      check("midrst quiet", 32'(seen), 32'h0);
      @(posedge clk);
      #1;
      run_txn('{2'd2, OP_PUSH, 16'hBEEF, 1'b0, 16'h0000}, "post push");
      run_txn('{2'd2, OP_POP,  16'h0000, 1'b0, 16'hBEEF}, "post pop");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Strobe exclusivity across the whole run
   always @(negedge clk) begin
      if (!rst && lifo_push && lifo_pop) begin
         checks++;
         failures++;
         $display("FAIL strobe excl: got push=1 pop=1 expected at most one");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1);
   end
endmodule
